// File: rtl/rk8e_dma_break.sv
// rk8e_dma_break - data-break (DMA) arbiter between the RK8E disk engine and
// PDP-8 core memory.
//
// The disk engine asks for one word at a time. The request waits for a free
// CPU memory slot, runs a single memory cycle, and then completes with a
// one-cycle grant. A burst limit makes sure the CPU still gets memory
// cycles while a whole sector is being moved.
//
// Optional feature macro: RK8E_DMA_TIMEOUT_EN
//   defined   - a watchdog counts ARB cycles without cpu_slot. When it
//               expires, the request ends with dma_err set and a grant, and
//               no memory access is made.
//   undefined - ARB waits for a CPU slot indefinitely.
//
// Parameters:
//   MEM_LAT   cycles from mem_re to valid mem_rdata (1..7)
//   BURST_MAX consecutive breaks allowed before one CPU slot is yielded (1..15)
//   TMO_CYC   watchdog limit in cycles (1..255, timeout build only)
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   clear              IOCLR, same effect as reset
//   dma_req/rd/wr      one-word request and its direction
//   dma_addr/dma_dout  15-bit field+word address, write data
//   dma_din            read data returned to the disk (held until next read)
//   dma_gnt            one-cycle completion pulse
//   cpu_slot           CPU is not using memory this cycle
//   break_act          break owns memory, CPU must stall
//   mem_*              core memory interface
//   dma_err            sticky illegal-request / timeout flag
//   brk_count          completed-break counter, wraps 7777 -> 0000
//
// State | Meaning
// ------+--------------------------------------------------------------
// IDLE  | no request in progress, waiting for dma_req
// ARB   | request latched, waiting for a CPU slot (or burst yield)
// MEM   | memory cycle running: mem_we for 1 cycle or mem_re for MEM_LAT
// ACK   | grant pulse, counters advance
// ERRACK| grant pulse for an illegal (or timed-out) request, no memory use

module rk8e_dma_break #(
    parameter int MEM_LAT   = 1,
    parameter int BURST_MAX = 4,
    parameter int TMO_CYC   = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        dma_req,
    input  logic        dma_rd,
    input  logic        dma_wr,
    input  logic [0:14] dma_addr,
    input  logic [0:11] dma_dout,
    output logic [0:11] dma_din,
    output logic        dma_gnt,
    input  logic        cpu_slot,
    output logic        break_act,
    output logic [0:14] mem_addr,
    output logic [0:11] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [0:11] mem_rdata,
    output logic        dma_err,
    output logic [0:11] brk_count
);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_lat
            $error("rk8e_dma_break: MEM_LAT must be 1..7");
        end
        if (BURST_MAX < 1 || BURST_MAX > 15) begin : g_bad_burst
            $error("rk8e_dma_break: BURST_MAX must be 1..15");
        end
        if (TMO_CYC < 1 || TMO_CYC > 255) begin : g_bad_tmo
            $error("rk8e_dma_break: TMO_CYC must be 1..255");
        end
    endgenerate

    localparam logic [2:0] LAT_LOAD  = 3'(MEM_LAT - 1);
    localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_MEM,
        S_ACK,
        S_ERRACK
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic        abort;
    logic        req_ok;
    logic        req_bad;
    logic        burst_full;
    logic        lat_done;

    logic        is_rd_q;
    logic [0:14] addr_q;
    logic [0:11] data_q;
    logic [2:0]  lat_cnt_q;
    logic [3:0]  burst_q;
    logic [0:11] brk_q;
    logic [0:11] din_q;
    logic        err_q;

    assign abort      = reset | clear;
    assign req_ok     = dma_req & (dma_rd ^ dma_wr);
    assign req_bad    = dma_req & ~(dma_rd ^ dma_wr);
    assign burst_full = (burst_q >= BURST_LIM);
    assign lat_done   = (lat_cnt_q == 3'd0);

`ifdef RK8E_DMA_TIMEOUT_EN
    logic [7:0] tmo_q;
    logic       tmo_hit;

    // Down-counter loaded in IDLE; expires on the TMO_CYC-th slotless ARB cycle.
    assign tmo_hit = (state_q == S_ARB) && !cpu_slot && (tmo_q <= 8'd1);

    always_ff @(posedge clk) begin
        if (abort) begin
            tmo_q <= 8'(TMO_CYC);
        end else if (state_q == S_IDLE) begin
            tmo_q <= 8'(TMO_CYC);
        end else if (state_q == S_ARB && !cpu_slot && tmo_q != 8'd0) begin
            tmo_q <= tmo_q - 8'd1;
        end
    end
`else
    logic tmo_hit;
    assign tmo_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (abort) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_ok) begin
                    state_d = S_ARB;
                end else if (req_bad) begin
                    state_d = S_ERRACK;
                end
            end
            S_ARB: begin
                // A slot seen with the burst counter full is given to the CPU.
                if (cpu_slot && !burst_full) begin
                    state_d = S_MEM;
                end else if (tmo_hit) begin
                    state_d = S_ERRACK;
                end
            end
            S_MEM: begin
                if (!is_rd_q || lat_done) begin
                    state_d = S_ACK;
                end
            end
            S_ACK:    state_d = S_IDLE;
            S_ERRACK: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (abort) begin
            is_rd_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            lat_cnt_q <= '0;
            burst_q   <= '0;
            brk_q     <= '0;
            din_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            if ((state_q == S_IDLE && req_bad) || tmo_hit) begin
                err_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (req_ok) begin
                        is_rd_q <= dma_rd;
                        addr_q  <= dma_addr;
                        data_q  <= dma_dout;
                    end
                    if (!dma_req) begin
                        burst_q <= '0;
                    end
                end
                S_ARB: begin
                    lat_cnt_q <= LAT_LOAD;
                    if (cpu_slot && burst_full) begin
                        burst_q <= '0;
                    end
                end
                S_MEM: begin
                    if (is_rd_q) begin
                        lat_cnt_q <= lat_cnt_q - 3'd1;
                        if (lat_done) begin
                            din_q <= mem_rdata;
                        end
                    end
                end
                S_ACK: begin
                    brk_q <= brk_q + 12'd1;
                    if (!burst_full) begin
                        burst_q <= burst_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs. Strobes and grant are suppressed in the reset/clear cycle so
    // an aborted transfer never touches memory on the way out.
    always_comb begin
        break_act = 1'b0;
        dma_gnt   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        case (state_q)
            S_MEM: begin
                break_act = 1'b1;
                mem_addr  = addr_q;
                if (is_rd_q) begin
                    mem_re = ~abort;
                end else begin
                    mem_we    = ~abort;
                    mem_wdata = data_q;
                end
            end
            S_ACK: begin
                break_act = 1'b1;
                dma_gnt   = ~abort;
            end
            S_ERRACK: begin
                dma_gnt = ~abort;
            end
            default: ;
        endcase
    end

    assign dma_din   = din_q;
    assign dma_err   = err_q;
    assign brk_count = brk_q;

endmodule

// File: tb/tb_rk8e_dma_break.sv
// Self-checking bench for rk8e_dma_break (default build, MEM_LAT=3,
// BURST_MAX=4). A transaction-level model predicts grant timing, strobe
// counts, read data, error flag and break count from the arbitration rules.

module tb_rk8e_dma_break;

    localparam int LAT  = 3;
    localparam int BMAX = 4;

    logic        clk = 1'b0;
    logic        reset, clear;
    logic        dma_req, dma_rd, dma_wr;
    logic [0:14] dma_addr;
    logic [0:11] dma_dout, dma_din;
    logic        dma_gnt, cpu_slot, break_act;
    logic [0:14] mem_addr;
    logic [0:11] mem_wdata, mem_rdata, brk_count;
    logic        mem_we, mem_re, dma_err;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          m_burst = 0;
    int          m_brk   = 0;
    logic [11:0] m_din   = '0;
    logic        m_err   = 1'b0;
    bit          slots[128];

    always #5 clk = ~clk;

    rk8e_dma_break #(.MEM_LAT(LAT), .BURST_MAX(BMAX), .TMO_CYC(20)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .dma_req(dma_req), .dma_rd(dma_rd), .dma_wr(dma_wr),
        .dma_addr(dma_addr), .dma_dout(dma_dout), .dma_din(dma_din),
        .dma_gnt(dma_gnt), .cpu_slot(cpu_slot), .break_act(break_act),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_rdata(mem_rdata), .dma_err(dma_err),
        .brk_count(brk_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_burst = 0;
        m_brk   = 0;
        m_din   = '0;
        m_err   = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 64'({dma_din, dma_gnt, break_act, mem_addr, mem_wdata,
                      mem_we, mem_re, dma_err, brk_count}), 64'd0);
    endtask

    task automatic idle(input int n);
        dma_req = 1'b0;
        dma_rd  = 1'b0;
        dma_wr  = 1'b0;
        repeat (n) next_cyc();
        m_burst = 0;
    endtask

    // 0: CPU always idle, 1: random slots, 2: 50 stalled cycles
    task automatic set_slots(input int mode);
        for (int i = 0; i < 128; i++) begin
            if (i >= 100 || mode == 0) slots[i] = 1'b1;
            else if (mode == 1)        slots[i] = ($urandom_range(0, 2) != 0);
            else                       slots[i] = (i == 0 || i > 50);
        end
    endtask

    // Runs one request starting in the current (IDLE) cycle, checks it, and
    // returns in the IDLE cycle that follows the grant.
    task automatic run_xfer(input bit rd, input bit wr, input logic [14:0] a,
                            input logic [11:0] d, input logic [11:0] rdat);
        int   t, b, n_mem, exp_gnt, gnt_at, we_n, re_n, ba_n, cyc;
        bit   legal, addr_ok;
        legal = rd ^ wr;
        n_mem = rd ? LAT : 1;
        b     = m_burst;
        if (!legal) begin
            exp_gnt = 1;
        end else begin
            t = 1;
            while (t < 120) begin
                if (slots[t]) begin
                    if (b == BMAX) b = 0;
                    else break;
                end
                t++;
            end
            exp_gnt = t + 1 + n_mem;
        end

        dma_req  = 1'b1;
        dma_rd   = rd;
        dma_wr   = wr;
        dma_addr = a;
        dma_dout = d;
        gnt_at = -1; we_n = 0; re_n = 0; ba_n = 0; addr_ok = 1'b1; cyc = 0;
        forever begin
            mem_rdata = (legal && rd && cyc == exp_gnt - 1) ? rdat : 12'($urandom);
            cpu_slot  = (cyc < 128) ? slots[cyc] : 1'b1;
            #1;
            if (mem_we) begin
                we_n++;
                if (mem_addr !== a || mem_wdata !== d) addr_ok = 1'b0;
            end
            if (mem_re) begin
                re_n++;
                if (mem_addr !== a) addr_ok = 1'b0;
            end
            if (break_act) ba_n++;
            if (dma_gnt) begin
                gnt_at = cyc;
                chk("din_at_gnt", 64'(dma_din), 64'((legal && rd) ? rdat : m_din));
                break;
            end
            if (cyc >= exp_gnt + 8) break;
            next_cyc();
            cyc++;
        end

        if (legal) begin
            m_burst = (b + 1 > BMAX) ? BMAX : b + 1;
            m_brk   = (m_brk + 1) % 4096;
            if (rd) m_din = rdat;
        end else begin
            m_err = 1'b1;
        end

        chk("gnt_cycle", 64'(gnt_at), 64'(exp_gnt));
        chk("mem_we_count", 64'(we_n), 64'((legal && wr) ? 1 : 0));
        chk("mem_re_count", 64'(re_n), 64'((legal && rd) ? LAT : 0));
        chk("break_act_cycles", 64'(ba_n), 64'(legal ? n_mem + 1 : 0));
        chk("mem_addr_data", 64'(addr_ok), 64'd1);
        chk("dma_err", 64'(dma_err), 64'(m_err));

        next_cyc();
        #1;
        chk("gnt_single_pulse", 64'({dma_gnt, break_act}), 64'd0);
        chk("brk_count", 64'(brk_count), 64'(m_brk));
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0;
        dma_req = 1'b0; dma_rd = 1'b0; dma_wr = 1'b0;
        dma_addr = '0; dma_dout = '0; cpu_slot = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk_all_zero("reset_outputs");

        // directed write and read
        idle(2);
        set_slots(0);
        run_xfer(1'b0, 1'b1, 15'o10200, 12'o3456, 12'o0);
        run_xfer(1'b1, 1'b0, 15'o07777, 12'o0, 12'o5252);

        // burst limit: 6 back-to-back writes, the 5th yields one slot
        idle(1);
        for (int i = 0; i < 6; i++)
            run_xfer(1'b0, 1'b1, 15'($urandom), 12'($urandom), 12'o0);

        // CPU busy for 50 cycles
        idle(1);
        set_slots(2);
        run_xfer(1'b0, 1'b1, 15'o01234, 12'o7070, 12'o0);

        // illegal requests, then a legal write still completes
        set_slots(0);
        run_xfer(1'b1, 1'b1, 15'o00100, 12'o1111, 12'o0);
        run_xfer(1'b0, 1'b1, 15'o00100, 12'o2222, 12'o0);
        run_xfer(1'b0, 1'b0, 15'o00200, 12'o3333, 12'o0);
        run_xfer(1'b1, 1'b0, 15'o00200, 12'o0, 12'o4444);

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            bit r, w;
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            set_slots(($urandom_range(0, 2) == 0) ? 0 : 1);
            r = 1'($urandom_range(0, 1));
            w = !r;
            if ($urandom_range(0, 9) == 0) w = r;
            run_xfer(r, w, 15'($urandom), 12'($urandom), 12'($urandom));
        end

        // reset in the middle of a read's MEM phase
        idle(2);
        dma_req = 1'b1; dma_rd = 1'b1; dma_wr = 1'b0;
        dma_addr = 15'o07777; cpu_slot = 1'b1; mem_rdata = 12'o1111;
        next_cyc();
        next_cyc();
        #1;
        chk("pre_reset_mem_re", 64'(mem_re), 64'd1);
        next_cyc();
        reset = 1'b1;
        #1;
        chk("reset_cycle_no_strobe", 64'({mem_we, dma_gnt}), 64'd0);
        next_cyc();
        reset = 1'b0;
        dma_req = 1'b0;
        #1;
        chk_all_zero("after_reset_in_mem");
        model_reset();
        next_cyc();
        #1;
        chk("idle_after_reset", 64'({break_act, mem_re, mem_we, dma_gnt}), 64'd0);

        // clear while waiting in ARB, with dma_err set beforehand
        set_slots(0);
        run_xfer(1'b1, 1'b1, 15'o0, 12'o0, 12'o0);
        dma_req = 1'b1; dma_rd = 1'b0; dma_wr = 1'b1; cpu_slot = 1'b0;
        next_cyc();
        next_cyc();
        clear = 1'b1;
        next_cyc();
        clear = 1'b0;
        dma_req = 1'b0;
        #1;
        chk_all_zero("after_clear");
        model_reset();
        cpu_slot = 1'b1;
        next_cyc();
        #1;
        chk("no_resume_after_clear", 64'({break_act, mem_we}), 64'd0);

        // brk_count wrap after 4096 grants
        idle(1);
        set_slots(0);
        for (int i = 0; i < 4095; i++)
            run_xfer(1'b0, 1'b1, 15'($urandom), 12'($urandom), 12'o0);
        chk("brk_count_7777", 64'(brk_count), 64'(12'o7777));
        run_xfer(1'b0, 1'b1, 15'o00001, 12'o0001, 12'o0);
        chk("brk_count_wrap", 64'(brk_count), 64'd0);

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rk8e_dma_break.md
Name: rk8e_dma_break

Overview:
- Data-break (DMA) arbiter between the SD disk engine's DMA port and PDP-8 core memory.
- Accepts one-word read/write requests, waits for a CPU memory slot, runs the memory cycle, then returns a one-cycle grant with read data.
- Replaces the "grant = registered request" shortcut in the RK8E controller.
- Enforces a burst limit so the CPU is never starved during 256-word sector transfers.

Parameters:
- MEM_LAT, 1: cycles from mem_re assertion to mem_rdata valid (1..7).
- BURST_MAX, 4: max consecutive breaks before one CPU slot must pass (1..15).
- TMO_CYC, 255: watchdog limit in cycles, used only with the optional feature (8-bit).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- clear  in  1  IOCLR, synchronous; same effect as reset on this block
- dma_req  in  1  transfer request from the disk engine
- dma_rd  in  1  memory-to-disk (read) request
- dma_wr  in  1  disk-to-memory (write) request
- dma_addr  in  [0:14]  field + word address
- dma_dout  in  [0:11]  write data from the disk
- dma_din  out  [0:11]  read data to the disk
- dma_gnt  out  1  one-cycle completion pulse
- cpu_slot  in  1  CPU not using memory this cycle
- break_act  out  1  break owns memory; CPU must stall
- mem_addr  out  [0:14]  memory address
- mem_wdata  out  [0:11]  memory write data
- mem_we  out  1  memory write strobe
- mem_re  out  1  memory read strobe
- mem_rdata  in  [0:11]  memory read data
- dma_err  out  1  sticky: illegal request (or timeout)
- brk_count  out  [0:11]  completed-break counter, wraps 7777->0000

Behaviour:
- Reset/clear values: all outputs 0; state IDLE; burst counter 0.
- Reset or clear mid-transfer aborts immediately. No mem_we is issued in the reset cycle.
- Requester rule: dma_req, dma_rd/dma_wr, dma_addr and dma_dout stay stable until the dma_gnt cycle. Changing them earlier is undefined.
- IDLE: dma_req=1 with exactly one of rd/wr moves to ARB. Latch addr, data and direction at this point.
  - dma_req=1 with rd=wr=1 or rd=wr=0: set dma_err, go to ERRACK, pulse dma_gnt next cycle, no memory access.
- ARB: if cpu_slot=1 and burst counter < BURST_MAX, go to MEM with break_act=1. Otherwise hold.
  - If the burst counter equals BURST_MAX, the first cpu_slot cycle is yielded: counter clears, state stays ARB.
- MEM write: mem_we=1 for exactly 1 cycle with latched addr/data, then go to ACK.
- MEM read: mem_re=1 for MEM_LAT cycles. Capture mem_rdata into dma_din on the last cycle, then go to ACK.
- break_act is high for every cycle in MEM and ACK.
- ACK: dma_gnt=1 for one cycle; brk_count+1; burst counter+1 (saturates at BURST_MAX). Return to IDLE.
- dma_din holds its value until the next read completes.
- Burst counter clears on any IDLE cycle with dma_req=0.
- Minimum latency from dma_req to dma_gnt: write = 3 cycles (IDLE→ARB→MEM→ACK); read = 2+MEM_LAT.
- dma_err is cleared only by reset or clear.

Optional Feature:
- Macro: RK8E_DMA_TIMEOUT_EN.
- Defined: an 8-bit counter runs in ARB and counts cycles without cpu_slot. On reaching TMO_CYC the block sets dma_err, pulses dma_gnt with no memory access, and returns to IDLE.
- Undefined: ARB waits indefinitely; dma_err flags illegal requests only.

Test Plan:
- Write 03456 to addr 1 0200 with cpu_slot=1: one mem_we, mem_addr=10200, mem_wdata=3456; dma_gnt 3 cycles after req; brk_count=0001.
- Read addr 07777 with mem_rdata=5252 and MEM_LAT=3: mem_re high 3 cycles; dma_din=5252 at the dma_gnt cycle; no mem_we.
- Continuous requests with BURST_MAX=4 and cpu_slot=1: after 4 grants, one cpu_slot cycle passes with break_act=0, then breaks resume.
- cpu_slot=0 for 50 cycles: block stays in ARB, no strobes, no gnt. Raising cpu_slot completes the transfer. With the macro and TMO_CYC=20: dma_err=1, gnt at cycle 21, no memory access.
- dma_req with rd=wr=1: dma_err=1, one dma_gnt, no mem_we/mem_re. A following legal write still completes.
- Reset asserted in MEM during a read: next cycle all outputs 0, state IDLE, brk_count=0000; a 4096th grant wraps brk_count to 0000.
